eeprom_cmd_seq: RTL and testbench

- Automatic command sequencer between the UART RX FIFO and the EEPROM controller; replaces the manual key sequence (pop, request, push, transmit).
- Pops one 64-bit command, issues a single request to the EEPROM controller and waits for the transaction to finish.
- For read commands, pushes a tagged 64-bit response into the UART TX FIFO and kicks transmission.
- On controller timeout, reports an error frame to the host.

---
 rtl/eeprom_cmd_pkg.sv | 27 ++
 rtl/seq_timeout_cnt.sv | 31 +++
 rtl/eeprom_cmd_seq.sv | 157 +++++++++++++++
 tb/tb_eeprom_cmd_seq.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eeprom_cmd_pkg.sv
// rtl/eeprom_cmd_pkg.sv - shared types and constants for the EEPROM command sequencer
// Contents: sequencer state enum, command word field positions, control-byte
// read flag position, timer width and default response tags.
package eeprom_cmd_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LATCH,
      ST_REQ,
      ST_WAIT_HI,
      ST_WAIT_LO,
      ST_ERR,
      ST_PUSH,
      ST_KICK
   } seq_state_t;

   localparam int CMD_CTRL_MSB = 63;
   localparam int CMD_CTRL_LSB = 56;
   localparam int CMD_DATA_MSB = 31;
   localparam int CTRL_RD_BIT  = 0;

   localparam int TMR_W = 24;

   localparam logic [31:0] DEF_RESP_TAG = 32'hAACCDDEE;
   localparam logic [31:0] DEF_ERR_TAG  = 32'hEEEE0BAD;

endpackage

// File: rtl/seq_timeout_cnt.sv
// rtl/seq_timeout_cnt.sv - 24-bit saturating wait timer with clear and compare
// Ports:
//   sys_clk, sys_rst_n : clock, asynchronous active-low reset
//   clear              : forces the count back to zero on the next edge
//   limit              : compare value
//   expired            : high while the count is at or beyond limit
module seq_timeout_cnt
   import eeprom_cmd_pkg::*;
(
   input  logic             sys_clk,
   input  logic             sys_rst_n,
   input  logic             clear,
   input  logic [TMR_W-1:0] limit,
   output logic             expired
);

   logic [TMR_W-1:0] count;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (count != '1) begin
         count <= count + 1'b1;
      end
   end

   assign expired = (count >= limit);

endmodule

// File: rtl/eeprom_cmd_seq.sv
// rtl/eeprom_cmd_seq.sv - sequencer from UART RX FIFO commands to EEPROM controller and TX responses
// Build option: WRITE_ECHO_EN - when defined, write commands also push {RESP_TAG, write data}.
// Ports:
//   sys_clk, sys_rst_n              : clock, asynchronous active-low reset
//   enable                          : accept new commands while high
//   rx_fifo_empty/rd_en/dout        : command FIFO (dout valid the cycle after rd_en)
//   eep_ctrl_byte/data_in/req       : request to EEPROM controller
//   eep_busy/data_out               : controller status and read data
//   tx_fifo_full/wr_en/din          : response FIFO
//   tx_busy/tx_enable               : UART transmit engine status and kick
//   seq_busy                        : sequencer not idle
//   cmd_cnt, err_cnt                : completed commands (wrapping), timeouts (saturating)
module eeprom_cmd_seq
   import eeprom_cmd_pkg::*;
#(
   parameter int          START_TIMEOUT = 1000,
   parameter int          BUSY_TIMEOUT  = 5_000_000,
   parameter logic [31:0] RESP_TAG      = DEF_RESP_TAG,
   parameter logic [31:0] ERR_TAG       = DEF_ERR_TAG
)(
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic        enable,
   input  logic        rx_fifo_empty,
   output logic        rx_fifo_rd_en,
   input  logic [63:0] rx_fifo_dout,
   output logic [7:0]  eep_ctrl_byte,
   output logic [31:0] eep_data_in,
   output logic        eep_req,
   input  logic        eep_busy,
   input  logic [31:0] eep_data_out,
   input  logic        tx_fifo_full,
   output logic        tx_fifo_wr_en,
   output logic [63:0] tx_fifo_din,
   input  logic        tx_busy,
   output logic        tx_enable,
   output logic        seq_busy,
   output logic [15:0] cmd_cnt,
   output logic [7:0]  err_cnt
);

   localparam logic [TMR_W-1:0] START_LIMIT = TMR_W'(START_TIMEOUT);
   localparam logic [TMR_W-1:0] BUSY_LIMIT  = TMR_W'(BUSY_TIMEOUT);

   seq_state_t       state;
   logic             from_err;
   logic             tmr_clear;
   logic             tmr_expired;
   logic [TMR_W-1:0] tmr_limit;
   logic             unused_rsvd;

   assign unused_rsvd = ^rx_fifo_dout[55:32];

   // Timer is held at zero while idle, so the start timeout counts from the pop;
   // it restarts when busy rises so the busy timeout covers only the busy phase.
   assign tmr_clear = (state == ST_IDLE) || ((state == ST_WAIT_HI) && eep_busy);
   assign tmr_limit = (state == ST_WAIT_LO) ? BUSY_LIMIT : START_LIMIT;

   seq_timeout_cnt u_timer (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .clear     (tmr_clear),
      .limit     (tmr_limit),
      .expired   (tmr_expired)
   );

   assign seq_busy = (state != ST_IDLE);

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state         <= ST_IDLE;
         from_err      <= 1'b0;
         rx_fifo_rd_en <= 1'b0;
         eep_req       <= 1'b0;
         tx_fifo_wr_en <= 1'b0;
         tx_enable     <= 1'b0;
         eep_ctrl_byte <= '0;
         eep_data_in   <= '0;
         tx_fifo_din   <= '0;
         cmd_cnt       <= '0;
         err_cnt       <= '0;
      end else begin
         rx_fifo_rd_en <= 1'b0;
         eep_req       <= 1'b0;
         tx_fifo_wr_en <= 1'b0;
         tx_enable     <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (enable && !rx_fifo_empty) begin
                  rx_fifo_rd_en <= 1'b1;
                  state         <= ST_LATCH;
               end
            end
            // The pop strobe is registered, so the FIFO sees it at the end of
            // this cycle; the popped word is on rx_fifo_dout during REQ.
            ST_LATCH: state <= ST_REQ;
            ST_REQ: begin
               eep_ctrl_byte <= rx_fifo_dout[CMD_CTRL_MSB:CMD_CTRL_LSB];
               eep_data_in   <= rx_fifo_dout[CMD_DATA_MSB:0];
               eep_req       <= 1'b1;
               from_err      <= 1'b0;
               state         <= ST_WAIT_HI;
            end
            ST_WAIT_HI: begin
               if (eep_busy) begin
                  state <= ST_WAIT_LO;
               end else if (tmr_expired) begin
                  state <= ST_ERR;
               end
            end
            ST_WAIT_LO: begin
               if (!eep_busy) begin
                  if (eep_ctrl_byte[CTRL_RD_BIT]) begin
                     tx_fifo_din <= {RESP_TAG, eep_data_out};
                     state       <= ST_PUSH;
                  end else begin
`ifdef WRITE_ECHO_EN
                     tx_fifo_din <= {RESP_TAG, eep_data_in};
                     state       <= ST_PUSH;
`else
                     cmd_cnt <= cmd_cnt + 1'b1;
                     state   <= ST_IDLE;
`endif
                  end
               end else if (tmr_expired) begin
                  state <= ST_ERR;
               end
            end
            ST_ERR: begin
               if (err_cnt != '1) begin
                  err_cnt <= err_cnt + 1'b1;
               end
               tx_fifo_din <= {ERR_TAG, eep_ctrl_byte, 24'h0};
               from_err    <= 1'b1;
               state       <= ST_PUSH;
            end
            ST_PUSH: begin
               if (!tx_fifo_full) begin
                  tx_fifo_wr_en <= 1'b1;
                  state         <= ST_KICK;
               end
            end
            ST_KICK: begin
               if (!tx_busy) begin
                  tx_enable <= 1'b1;
                  if (!from_err) begin
                     cmd_cnt <= cmd_cnt + 1'b1;
                  end
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_eeprom_cmd_seq.sv
// tb/tb_eeprom_cmd_seq.sv - self-checking bench for eeprom_cmd_seq
module tb_eeprom_cmd_seq;

   logic        sys_clk;
   logic        sys_rst_n;
   logic        enable;
   logic        rx_fifo_empty;
   logic        rx_fifo_rd_en;
   logic [63:0] rx_fifo_dout;
   logic [7:0]  eep_ctrl_byte;
   logic [31:0] eep_data_in;
   logic        eep_req;
   logic        eep_busy;
   logic [31:0] eep_data_out;
   logic        tx_fifo_full;
   logic        tx_fifo_wr_en;
   logic [63:0] tx_fifo_din;
   logic        tx_busy;
   logic        tx_enable;
   logic        seq_busy;
   logic [15:0] cmd_cnt;
   logic [7:0]  err_cnt;

   eeprom_cmd_seq #(.START_TIMEOUT(16)) dut (
      .sys_clk       (sys_clk),
      .sys_rst_n     (sys_rst_n),
      .enable        (enable),
      .rx_fifo_empty (rx_fifo_empty),
      .rx_fifo_rd_en (rx_fifo_rd_en),
      .rx_fifo_dout  (rx_fifo_dout),
      .eep_ctrl_byte (eep_ctrl_byte),
      .eep_data_in   (eep_data_in),
      .eep_req       (eep_req),
      .eep_busy      (eep_busy),
      .eep_data_out  (eep_data_out),
      .tx_fifo_full  (tx_fifo_full),
      .tx_fifo_wr_en (tx_fifo_wr_en),
      .tx_fifo_din   (tx_fifo_din),
      .tx_busy       (tx_busy),
      .tx_enable     (tx_enable),
      .seq_busy      (seq_busy),
      .cmd_cnt       (cmd_cnt),
      .err_cnt       (err_cnt)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   int checks = 0;
   int failures = 0;

   // environment model state
   int          cyc = 0;
   logic [63:0] rxq[$];
   bit          pend_pop = 0;
   bit          eep_resp = 1;
   int          hi_from = 0;
   int          hi_len = 0;
   logic [31:0] rd_val = '0;
   int          full_until = 0;
   int          txb_until = 0;

   // observations
   int          n_rd = 0, n_req = 0, n_wr = 0, n_txen = 0;
   int          rd_cyc = 0, req_cyc = 0, wr_cyc = 0, txen_cyc = 0;
   logic [7:0]  req_ctrl = '0;
   logic [31:0] req_data = '0;
   logic [63:0] wr_din = '0;
   bit          p_seq_busy = 0;
   int          viol_rd = 0, viol_wr = 0, viol_txen = 0;

   // One clock: sample DUT outputs 1 time unit after the edge, then update the
   // FIFO, EEPROM and UART models that drive the DUT inputs for the next edge.
   task automatic step();
      @(posedge sys_clk);
      #1;
      cyc++;
      if (rx_fifo_rd_en) begin
         n_rd++;
         rd_cyc = cyc;
         if (p_seq_busy) viol_rd++;
      end
      if (eep_req) begin
         n_req++;
         req_cyc  = cyc;
         req_ctrl = eep_ctrl_byte;
         req_data = eep_data_in;
         if (eep_resp) hi_from = cyc + 1;
      end
      if (tx_fifo_wr_en) begin
         n_wr++;
         wr_cyc = cyc;
         wr_din = tx_fifo_din;
         if (tx_fifo_full) viol_wr++;
      end
      if (tx_enable) begin
         n_txen++;
         txen_cyc = cyc;
         if (tx_busy) viol_txen++;
      end
      p_seq_busy = seq_busy;
      if (pend_pop && rxq.size() > 0) rx_fifo_dout = rxq.pop_front();
      pend_pop      = rx_fifo_rd_en;
      rx_fifo_empty = (rxq.size() == 0);
      eep_busy      = eep_resp && (hi_from > 0) && (cyc >= hi_from) && (cyc < hi_from + hi_len);
      eep_data_out  = rd_val;
      tx_fifo_full  = (cyc < full_until);
      tx_busy       = (cyc < txb_until);
   endtask

   task automatic wait_idle(input int max_cyc, output bit ok);
      int n = 0;
      while (!seq_busy && n < max_cyc) begin step(); n++; end
      while (seq_busy && n < max_cyc) begin step(); n++; end
      ok = !seq_busy && (n < max_cyc);
   endtask

   task automatic load(input logic [63:0] w);
      rxq.push_back(w);
      rx_fifo_empty = 1'b0;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) step();
      checks++;
      if ({rx_fifo_rd_en, eep_req, tx_fifo_wr_en, tx_enable, seq_busy} !== 5'b0) begin
         failures++;
         $display("FAIL reset_strobes got %b expected 00000", {rx_fifo_rd_en, eep_req, tx_fifo_wr_en, tx_enable, seq_busy});
      end
      checks++;
      if ({eep_ctrl_byte, eep_data_in, tx_fifo_din} !== 104'h0) begin
         failures++;
         $display("FAIL reset_data got %h %h %h expected zeros", eep_ctrl_byte, eep_data_in, tx_fifo_din);
      end
      checks++;
      if ({cmd_cnt, err_cnt} !== 24'h0) begin
         failures++;
         $display("FAIL reset_counts got cmd=%0h err=%0h expected 0 0", cmd_cnt, err_cnt);
      end
      sys_rst_n = 1'b1;
      enable    = 1'b1;
      for (int i = 0; i < 4; i++) step();
      checks++;
      if (n_rd !== 0 || seq_busy !== 1'b0) begin
         failures++;
         $display("FAIL empty_no_pop got pops=%0d busy=%b expected 0 0", n_rd, seq_busy);
      end
   endtask

   task automatic test_write();
      bit ok;
      int rd0 = n_rd;
      int wr0 = n_wr;
      eep_resp = 1;
      hi_len   = 50;
      rd_val   = 32'hDEAD0000;
      load(64'h5000_0000_1234_5678);
      wait_idle(300, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL write_timeout got busy=%b expected idle", seq_busy); end
      checks++;
      if (n_rd - rd0 !== 1) begin failures++; $display("FAIL write_pops got %0d expected 1", n_rd - rd0); end
      checks++;
      if (req_cyc - rd_cyc !== 2) begin failures++; $display("FAIL write_req_lat got %0d expected 2", req_cyc - rd_cyc); end
      checks++;
      if (req_ctrl !== 8'h50 || req_data !== 32'h12345678) begin
         failures++;
         $display("FAIL write_req_fields got %h %h expected 50 12345678", req_ctrl, req_data);
      end
`ifdef WRITE_ECHO_EN
      checks++;
      if (n_wr - wr0 !== 1 || wr_din !== 64'hAACCDDEE_12345678) begin
         failures++;
         $display("FAIL write_echo_push got n=%0d din=%h expected 1 aaccddee12345678", n_wr - wr0, wr_din);
      end
      checks++;
      if (cyc - req_cyc !== 54) begin failures++; $display("FAIL write_done_lat got %0d expected 54", cyc - req_cyc); end
`else
      checks++;
      if (n_wr !== wr0) begin failures++; $display("FAIL write_no_push got %0d expected 0", n_wr - wr0); end
      checks++;
      if (cyc - req_cyc !== 52) begin failures++; $display("FAIL write_done_lat got %0d expected 52", cyc - req_cyc); end
`endif
      checks++;
      if (cmd_cnt !== 16'd1) begin failures++; $display("FAIL write_cmd_cnt got %0d expected 1", cmd_cnt); end
   endtask

   task automatic test_read();
      bit ok;
      int wr0 = n_wr;
      int tx0 = n_txen;
      hi_len = 5;
      rd_val = 32'hCAFEF00D;
      load(64'hA100_0000_0000_0000);
      wait_idle(200, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL read_timeout got busy=%b expected idle", seq_busy); end
      checks++;
      if (n_wr - wr0 !== 1 || wr_din !== 64'hAACCDDEE_CAFEF00D) begin
         failures++;
         $display("FAIL read_push got n=%0d din=%h expected 1 aaccddeecafef00d", n_wr - wr0, wr_din);
      end
      checks++;
      if (n_txen - tx0 !== 1 || txen_cyc <= wr_cyc) begin
         failures++;
         $display("FAIL read_kick got n=%0d at %0d expected 1 after %0d", n_txen - tx0, txen_cyc, wr_cyc);
      end
      checks++;
      if (cmd_cnt !== 16'd2) begin failures++; $display("FAIL read_cmd_cnt got %0d expected 2", cmd_cnt); end
   endtask

   task automatic test_backpressure();
      bit ok;
      int wr0 = n_wr;
      int tx0 = n_txen;
      hi_len       = 2;
      rd_val       = 32'h13572468;
      full_until   = cyc + 20;
      txb_until    = cyc + 30;
      tx_fifo_full = 1'b1;
      tx_busy      = 1'b1;
      load(64'h0300_0000_0000_0000);
      wait_idle(200, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL bp_timeout got busy=%b expected idle", seq_busy); end
      checks++;
      if (n_wr - wr0 !== 1 || n_txen - tx0 !== 1) begin
         failures++;
         $display("FAIL bp_counts got wr=%0d tx=%0d expected 1 1", n_wr - wr0, n_txen - tx0);
      end
      checks++;
      if (wr_cyc !== full_until + 1) begin failures++; $display("FAIL bp_wr_time got %0d expected %0d", wr_cyc, full_until + 1); end
      checks++;
      if (txen_cyc !== txb_until + 1) begin failures++; $display("FAIL bp_tx_time got %0d expected %0d", txen_cyc, txb_until + 1); end
      checks++;
      if (viol_wr !== 0 || viol_txen !== 0) begin
         failures++;
         $display("FAIL bp_strobe_while_blocked got wr=%0d tx=%0d expected 0 0", viol_wr, viol_txen);
      end
      checks++;
      if (wr_din !== 64'hAACCDDEE_13572468 || cmd_cnt !== 16'd3) begin
         failures++;
         $display("FAIL bp_result got din=%h cnt=%0d expected aaccddee13572468 3", wr_din, cmd_cnt);
      end
   endtask

   task automatic test_start_timeout();
      bit ok;
      int tx0 = n_txen;
      eep_resp = 0;
      load(64'h4100_0000_0000_0000);
      wait_idle(200, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL sto_timeout got busy=%b expected idle", seq_busy); end
      checks++;
      if (wr_cyc - req_cyc !== 17) begin failures++; $display("FAIL sto_push_time got %0d expected 17", wr_cyc - req_cyc); end
      checks++;
      if (wr_din !== 64'hEEEE0BAD_4100_0000) begin failures++; $display("FAIL sto_frame got %h expected eeee0bad41000000", wr_din); end
      checks++;
      if (err_cnt !== 8'd1 || cmd_cnt !== 16'd3 || n_txen - tx0 !== 1) begin
         failures++;
         $display("FAIL sto_counts got err=%0d cmd=%0d kicks=%0d expected 1 3 1", err_cnt, cmd_cnt, n_txen - tx0);
      end
      eep_resp = 1;
   endtask

   task automatic test_back_to_back();
      int rd0 = n_rd;
      int rq0 = n_req;
      int n = 0;
      hi_len = 4;
      rd_val = 32'h11112222;
      load(64'h2000_0000_AAAA_0001);
      load(64'h2100_0000_AAAA_0002);
      load(64'h2200_0000_AAAA_0003);
      while ((n_rd - rd0 < 3 || seq_busy) && n < 500) begin step(); n++; end
      checks++;
      if (n >= 500) begin failures++; $display("FAIL b2b_timeout got pops=%0d expected 3", n_rd - rd0); end
      checks++;
      if (n_rd - rd0 !== 3 || n_req - rq0 !== 3) begin
         failures++;
         $display("FAIL b2b_counts got pops=%0d reqs=%0d expected 3 3", n_rd - rd0, n_req - rq0);
      end
      checks++;
      if (viol_rd !== 0) begin failures++; $display("FAIL b2b_pop_while_busy got %0d expected 0", viol_rd); end
      checks++;
      if (cmd_cnt !== 16'd6) begin failures++; $display("FAIL b2b_cmd_cnt got %0d expected 6", cmd_cnt); end
      checks++;
      if (req_data !== 32'hAAAA0003) begin failures++; $display("FAIL b2b_last_data got %h expected aaaa0003", req_data); end
   endtask

   task automatic test_write_echo();
      bit ok;
      int wr0 = n_wr;
      int tx0 = n_txen;
      hi_len = 3;
      load(64'h0000_0000_0BAD_BEEF);
      wait_idle(200, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL echo_timeout got busy=%b expected idle", seq_busy); end
`ifdef WRITE_ECHO_EN
      checks++;
      if (n_wr - wr0 !== 1 || wr_din !== 64'hAACCDDEE_0BADBEEF || n_txen - tx0 !== 1) begin
         failures++;
         $display("FAIL echo_push got n=%0d din=%h kicks=%0d expected 1 aaccddee0badbeef 1", n_wr - wr0, wr_din, n_txen - tx0);
      end
`else
      checks++;
      if (n_wr !== wr0 || n_txen !== tx0) begin
         failures++;
         $display("FAIL echo_silent got wr=%0d tx=%0d expected 0 0", n_wr - wr0, n_txen - tx0);
      end
`endif
      checks++;
      if (cmd_cnt !== 16'd7) begin failures++; $display("FAIL echo_cmd_cnt got %0d expected 7", cmd_cnt); end
   endtask

   task automatic test_reset_mid();
      bit ok;
      int rq0 = n_req;
      int n = 0;
      int rd1, rq1, wr1, tx1;
      hi_len = 100;
      load(64'h3000_0000_0000_0001);
      load(64'h3000_0000_0000_0002);
      while (n_req - rq0 < 2 && n < 400) begin step(); n++; end
      for (int i = 0; i < 10; i++) step();
      load(64'h3000_0000_0000_0003);
      sys_rst_n = 1'b0;
      #1;
      checks++;
      if ({rx_fifo_rd_en, eep_req, tx_fifo_wr_en, tx_enable, seq_busy} !== 5'b0 ||
          {eep_ctrl_byte, eep_data_in, tx_fifo_din} !== 104'h0 || {cmd_cnt, err_cnt} !== 24'h0) begin
         failures++;
         $display("FAIL midrst_values got busy=%b ctrl=%h cnt=%0d err=%0d expected all zero", seq_busy, eep_ctrl_byte, cmd_cnt, err_cnt);
      end
      rd1 = n_rd;
      for (int i = 0; i < 5; i++) step();
      checks++;
      if (n_rd !== rd1) begin failures++; $display("FAIL midrst_pop_in_reset got %0d expected 0", n_rd - rd1); end
      enable    = 1'b0;
      sys_rst_n = 1'b1;
      rd1 = n_rd; rq1 = n_req; wr1 = n_wr; tx1 = n_txen;
      for (int i = 0; i < 10; i++) step();
      checks++;
      if (n_rd !== rd1 || n_req !== rq1 || n_wr !== wr1 || n_txen !== tx1 || seq_busy !== 1'b0) begin
         failures++;
         $display("FAIL midrst_quiet got rd=%0d rq=%0d wr=%0d tx=%0d expected 0 0 0 0", n_rd - rd1, n_req - rq1, n_wr - wr1, n_txen - tx1);
      end
      enable = 1'b1;
      wait_idle(400, ok);
      checks++;
      if (!ok || n_rd - rd1 !== 1 || cmd_cnt !== 16'd1 || req_data !== 32'h3) begin
         failures++;
         $display("FAIL midrst_resume got ok=%b pops=%0d cnt=%0d data=%h expected 1 1 1 3", ok, n_rd - rd1, cmd_cnt, req_data);
      end
   endtask

   initial begin
      sys_rst_n     = 1'b0;
      enable        = 1'b0;
      rx_fifo_empty = 1'b1;
      rx_fifo_dout  = '0;
      eep_busy      = 1'b0;
      eep_data_out  = '0;
      tx_fifo_full  = 1'b0;
      tx_busy       = 1'b0;
      test_reset();
      test_write();
      test_read();
      test_backpressure();
      test_start_timeout();
      test_back_to_back();
      test_write_echo();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
